// File: rtl/wb_arbiter.sv
// Writeback arbiter: one register-file write port shared by the single-cycle ALU
// and the long-latency LSU/MDU pipes, with age-based ALU stalling against starvation.
package wb_arbiter_pkg;
  typedef struct packed {
    logic        instruction_valid;
    logic        register_write;
    logic [4:0]  rd;
    logic [31:0] exe_result;
  } exe_wb_inf_t;
endpackage

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  exe_wb_inf_t alu_wb_inf,
  input  logic        lsu_valid,
  input  exe_wb_inf_t lsu_wb_inf,
  output logic        lsu_ready,
  input  logic        mdu_valid,
  input  exe_wb_inf_t mdu_wb_inf,
  output logic        mdu_ready,
  output logic        wb_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [1:0]  retire_cnt,
  output logic [63:0] instret
);

  localparam int unsigned AW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(STARVE_LIMIT);

  logic [AW-1:0] lsu_age;
  logic [AW-1:0] mdu_age;
  logic [AW-1:0] cand_age;
  logic          last_grant;
  logic          alu_writes;
  logic          pick_mdu;
  logic          port_free;
  logic          alu_take;
  logic          lsu_hs;
  logic          mdu_hs;
  logic          commit_any;
  logic [1:0]    retire_next;
  exe_wb_inf_t   commit;

  // last_grant=1 means MDU won most recently, so LSU has priority on a tie
  always_comb begin
    alu_writes  = alu_wb_inf.instruction_valid & alu_wb_inf.register_write;
    pick_mdu    = mdu_valid & (~lsu_valid | ~last_grant);
    cand_age    = pick_mdu ? mdu_age : lsu_age;
    wb_stall    = ~rst & alu_writes & (lsu_valid | mdu_valid) & (cand_age >= AGE_MAX);
    port_free   = ~alu_writes | wb_stall;
    lsu_ready   = ~rst & port_free & lsu_valid & ~pick_mdu;
    mdu_ready   = ~rst & port_free & pick_mdu;
    lsu_hs      = lsu_valid & lsu_ready;
    mdu_hs      = mdu_valid & mdu_ready;
    alu_take    = ~rst & alu_wb_inf.instruction_valid & ~wb_stall;
    retire_next = {1'b0, alu_take} + {1'b0, lsu_hs | mdu_hs};
    commit      = alu_wb_inf;
    commit_any  = 1'b1;
    if (alu_take && alu_wb_inf.register_write) begin
      commit = alu_wb_inf;
    end else if (lsu_hs) begin
      commit = lsu_wb_inf;
    end else if (mdu_hs) begin
      commit = mdu_wb_inf;
    end else begin
      commit_any = alu_take;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      retire_cnt <= '0;
      instret    <= '0;
      lsu_age    <= '0;
      mdu_age    <= '0;
      last_grant <= 1'b1;
    end else begin
      rf_we <= commit_any & commit.register_write & (commit.rd != 5'd0);
      if (commit_any) begin
        rf_waddr <= commit.rd;
        rf_wdata <= commit.exe_result;
      end
      retire_cnt <= retire_next;
      instret    <= instret + 64'(retire_next);
      if (lsu_hs) begin
        last_grant <= 1'b0;
      end else if (mdu_hs) begin
        last_grant <= 1'b1;
      end
      // Ages track consecutive waiting cycles and saturate at the limit
      if (!lsu_valid || lsu_hs) begin
        lsu_age <= '0;
      end else if (lsu_age < AGE_MAX) begin
        lsu_age <= lsu_age + AW'(1);
      end
      if (!mdu_valid || mdu_hs) begin
        mdu_age <= '0;
      end else if (mdu_age < AGE_MAX) begin
        mdu_age <= mdu_age + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a cycle-level reference model predicts every
// handshake and registered writeback; a monitor pops and compares after each edge.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  exe_wb_inf_t alu_wb_inf;
  logic        lsu_valid;
  exe_wb_inf_t lsu_wb_inf;
  logic        lsu_ready;
  logic        mdu_valid;
  exe_wb_inf_t mdu_wb_inf;
  logic        mdu_ready;
  logic        wb_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  retire_cnt;
  logic [63:0] instret;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  rc;
    logic [63:0] instret;
  } exp_t;

  exp_t exp_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  int              wait_cyc[2];
  int              last_src;
  logic [63:0]     m_instret;
  logic            alu_taken;
  logic            lsu_taken;
  logic            mdu_taken;

  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_inf(alu_wb_inf),
    .lsu_valid(lsu_valid), .lsu_wb_inf(lsu_wb_inf), .lsu_ready(lsu_ready),
    .mdu_valid(mdu_valid), .mdu_wb_inf(mdu_wb_inf), .mdu_ready(mdu_ready),
    .wb_stall(wb_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .retire_cnt(retire_cnt), .instret(instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exe_wb_inf_t mk(input logic v, input logic rw, input logic [4:0] rd,
                                     input logic [31:0] data);
    exe_wb_inf_t e;
    e.instruction_valid = v;
    e.register_write    = rw;
    e.rd                = rd;
    e.exe_result        = data;
    return e;
  endfunction

  function automatic exe_wb_inf_t randEntry(input int valid_pct);
    return mk($urandom_range(0, 99) < valid_pct, $urandom_range(0, 3) != 0,
              5'($urandom_range(0, 31)), $urandom);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    vec_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Drives one cycle, predicts its outcome from the arbitration rules, queues the registered result
  task automatic applyStimulus(input logic r, input exe_wb_inf_t alu, input logic lv,
                               input exe_wb_inf_t l, input logic mv, input exe_wb_inf_t m);
    int          pick;
    int          retire;
    logic        alu_w;
    logic        stall;
    logic        grant;
    logic        have;
    exe_wb_inf_t src[2];
    exe_wb_inf_t winner;
    exp_t        e;
    @(negedge clk);
    rst        = r;
    alu_wb_inf = alu;
    lsu_valid  = lv;
    lsu_wb_inf = l;
    mdu_valid  = mv;
    mdu_wb_inf = m;
    #1;
    src[0] = l;
    src[1] = m;
    pick   = -1;
    stall  = 1'b0;
    grant  = 1'b0;
    if (r) begin
      alu_taken  = 1'b0;
      e.we       = 1'b0;
      e.waddr    = '0;
      e.wdata    = '0;
      e.rc       = '0;
      e.instret  = '0;
      wait_cyc   = '{0, 0};
      last_src   = 1;
      m_instret  = '0;
    end else begin
      if (lv && mv) pick = (last_src == 1) ? 0 : 1;
      else if (lv) pick = 0;
      else if (mv) pick = 1;
      alu_w = alu.instruction_valid && alu.register_write;
      if (alu_w && pick >= 0) stall = (wait_cyc[pick] >= LIMIT);
      grant     = (pick >= 0) && (!alu_w || stall);
      alu_taken = alu.instruction_valid && !stall;
      retire    = int'(alu_taken) + int'(grant);
      have      = alu_taken || grant;
      if (alu_taken && alu.register_write) winner = alu;
      else if (grant) winner = src[pick];
      else winner = alu;
      e.we      = have && winner.register_write && (winner.rd != 5'd0);
      e.waddr   = winner.rd;
      e.wdata   = winner.exe_result;
      e.rc      = 2'(retire);
      m_instret = m_instret + 64'(retire);
      e.instret = m_instret;
      for (int s = 0; s < 2; s++) begin
        if (!(s == 0 ? lv : mv) || (grant && pick == s)) wait_cyc[s] = 0;
        else if (wait_cyc[s] < LIMIT) wait_cyc[s]++;
      end
      if (grant) last_src = pick;
    end
    lsu_taken = grant && (pick == 0);
    mdu_taken = grant && (pick == 1);
    checkOutput("wb_stall", wb_stall, stall);
    checkOutput("lsu_ready", lsu_ready, lsu_taken);
    checkOutput("mdu_ready", mdu_ready, mdu_taken);
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("rf_we", rf_we, e.we);
        if (e.we) begin
          checkOutput("rf_waddr", rf_waddr, e.waddr);
          checkOutput("rf_wdata", rf_wdata, e.wdata);
        end
        checkOutput("retire_cnt", retire_cnt, e.rc);
        checkOutput("instret", instret, e.instret);
      end
    end
  end

  initial begin
    exe_wb_inf_t idle;
    exe_wb_inf_t cur_alu;
    exe_wb_inf_t cur_lsu;
    exe_wb_inf_t cur_mdu;
    logic        cur_lv;
    logic        cur_mv;
    logic        cur_rst;
    idle       = mk(1'b0, 1'b0, 5'd0, 32'd0);
    rst        = 1'b1;
    alu_wb_inf = idle;
    lsu_valid  = 1'b0;
    lsu_wb_inf = idle;
    mdu_valid  = 1'b0;
    mdu_wb_inf = idle;

    applyStimulus(1'b1, idle, 1'b0, idle, 1'b0, idle);
    applyStimulus(1'b1, idle, 1'b0, idle, 1'b0, idle);

    $display("[TB] ALU add, then branch alongside a load");
    applyStimulus(1'b0, mk(1'b1, 1'b1, 5'd5, 32'h1234), 1'b0, idle, 1'b0, idle);
    applyStimulus(1'b0, mk(1'b1, 1'b0, 5'd0, 32'h0), 1'b1, mk(1'b1, 1'b1, 5'd7, 32'hDEAD),
                  1'b0, idle);
    applyStimulus(1'b0, idle, 1'b0, idle, 1'b0, idle);

    $display("[TB] LSU/MDU round-robin after reset");
    applyStimulus(1'b1, idle, 1'b0, idle, 1'b0, idle);
    applyStimulus(1'b0, idle, 1'b1, mk(1'b1, 1'b1, 5'd3, 32'h33), 1'b1, mk(1'b1, 1'b1, 5'd9, 32'h99));
    checkOutput("rr_first_lsu", lsu_taken, 1'b1);
    applyStimulus(1'b0, idle, 1'b1, mk(1'b1, 1'b1, 5'd4, 32'h44), 1'b1, mk(1'b1, 1'b1, 5'd9, 32'h99));
    checkOutput("rr_second_mdu", mdu_taken, 1'b1);
    applyStimulus(1'b0, idle, 1'b0, idle, 1'b0, idle);

    $display("[TB] MDU starvation against a writing ALU stream");
    cur_alu = mk(1'b1, 1'b1, 5'd10, 32'hA0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, cur_alu, 1'b0, idle, 1'b1, mk(1'b1, 1'b1, 5'd20, 32'hBEEF));
      checkOutput("starve_stall", wb_stall, i == 4);
      checkOutput("starve_mdu_ready", mdu_ready, i == 4);
      if (alu_taken) cur_alu = mk(1'b1, 1'b1, 5'(11 + i), 32'hA1 + i);
    end
    applyStimulus(1'b0, cur_alu, 1'b0, idle, 1'b0, idle);
    checkOutput("held_alu_taken", alu_taken, 1'b1);

    $display("[TB] ALU write to x0");
    applyStimulus(1'b0, mk(1'b1, 1'b1, 5'd0, 32'hFFFF), 1'b0, idle, 1'b0, idle);
    applyStimulus(1'b0, idle, 1'b0, idle, 1'b0, idle);

    $display("[TB] instret wrap and mid-stream reset");
    @(posedge clk);
    #2;
    force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    applyStimulus(1'b0, mk(1'b1, 1'b0, 5'd1, 32'h1), 1'b1, mk(1'b1, 1'b1, 5'd8, 32'h88),
                  1'b0, idle);
    applyStimulus(1'b1, mk(1'b1, 1'b1, 5'd6, 32'h66), 1'b1, mk(1'b1, 1'b1, 5'd2, 32'h22),
                  1'b1, mk(1'b1, 1'b1, 5'd3, 32'h33));
    applyStimulus(1'b1, idle, 1'b0, idle, 1'b0, idle);

    $display("[TB] randomized traffic");
    cur_alu = randEntry(70);
    cur_lsu = randEntry(100);
    cur_mdu = randEntry(100);
    cur_lv  = 1'b1;
    cur_mv  = 1'b0;
    for (int n = 0; n < 600; n++) begin
      cur_rst = ($urandom_range(0, 99) == 0);
      applyStimulus(cur_rst, cur_alu, cur_lv, cur_lsu, cur_mv, cur_mdu);
      if (!cur_alu.instruction_valid || alu_taken) cur_alu = randEntry(70);
      if (!cur_lv || lsu_taken) begin
        cur_lv  = ($urandom_range(0, 99) < 45);
        cur_lsu = randEntry(100);
      end
      if (!cur_mv || mdu_taken) begin
        cur_mv  = ($urandom_range(0, 99) < 45);
        cur_mdu = randEntry(100);
      end
    end
    applyStimulus(1'b0, idle, 1'b0, idle, 1'b0, idle);

    repeat (2) @(posedge clk);
    #2;
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
